// File: rtl/mem_arbiter.sv
// Memory arbiter: shares one single-outstanding memory port between an
// instruction fetch port and a load/store port. The LSU has priority, and a
// streak limit keeps fetch from starving. The LSU side aligns store data and
// byte enables, and extracts and extends load data.
module mem_arbiter #(
   parameter int unsigned MAX_STREAK = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   // fetch port
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_gnt,
   output logic        if_rvalid,
   output logic [31:0] if_rdata,
   // load/store port
   input  logic        ls_req,
   input  logic        ls_we,
   input  logic [31:0] ls_addr,
   input  logic [3:0]  ls_bsel,
   input  logic        ls_signed,
   input  logic [31:0] ls_wdata,
   output logic        ls_gnt,
   output logic        ls_rvalid,
   output logic [31:0] ls_rdata,
   output logic        ls_err,
   // memory port
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata
);

   localparam int unsigned STREAK_W = 4;
   localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_STREAK);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY_IF = 2'd1,
      BUSY_LS = 2'd2
   } state_e;

   state_e              state_q;
   logic [STREAK_W-1:0] streak_q;

   // registered outputs
   logic        if_rvalid_q;
   logic [31:0] if_rdata_q;
   logic        ls_rvalid_q;
   logic [31:0] ls_rdata_q;
   logic        ls_err_q;
   logic        mem_req_q;
   logic        mem_we_q;
   logic [31:0] mem_addr_q;
   logic [3:0]  mem_be_q;
   logic [31:0] mem_wdata_q;

   // load context kept for the in-flight LSU transaction
   logic [1:0]  ld_off_q;
   logic [3:0]  ld_bsel_q;
   logic        ld_signed_q;
   logic        ld_we_q;

   logic        idle_c;
   logic        fetch_wins_c;
   logic        ls_misaligned_c;
   logic [31:0] ld_shift_c;
   logic [31:0] ld_data_c;
   logic        if_addr_unused;

   // Fetch addresses are word addresses; the low bits are dropped.
   assign if_addr_unused = &if_addr[1:0];

   // Grants are only possible in IDLE and never while reset is asserted.
   assign idle_c       = rst_n && (state_q == IDLE);
   assign fetch_wins_c = if_req && (streak_q == STREAK_MAX);
   assign ls_gnt       = idle_c && ls_req && !fetch_wins_c;
   assign if_gnt       = idle_c && if_req && (!ls_req || fetch_wins_c);

   // Halfwords need even addresses and words need word-aligned addresses.
   assign ls_misaligned_c = ((ls_bsel == 4'b0011) && ls_addr[0]) ||
                            ((ls_bsel == 4'b1111) && (ls_addr[1:0] != 2'b00));

   // Align the returned word and then mask and extend it to the access size.
   always_comb begin
      ld_shift_c = mem_rdata >> {ld_off_q, 3'b000};
      ld_data_c  = ld_shift_c;
      case (ld_bsel_q)
         4'b0001: ld_data_c = {{24{ld_signed_q & ld_shift_c[7]}}, ld_shift_c[7:0]};
         4'b0011: ld_data_c = {{16{ld_signed_q & ld_shift_c[15]}}, ld_shift_c[15:0]};
         default: ld_data_c = ld_shift_c;
      endcase
   end

   // Arbitration FSM, streak counter and all registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         streak_q    <= '0;
         if_rvalid_q <= 1'b0;
         if_rdata_q  <= '0;
         ls_rvalid_q <= 1'b0;
         ls_rdata_q  <= '0;
         ls_err_q    <= 1'b0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_be_q    <= '0;
         mem_wdata_q <= '0;
         ld_off_q    <= '0;
         ld_bsel_q   <= '0;
         ld_signed_q <= 1'b0;
         ld_we_q     <= 1'b0;
      end else begin
         if_rvalid_q <= 1'b0;
         ls_rvalid_q <= 1'b0;
         ls_err_q    <= 1'b0;

         if (if_gnt) begin
            streak_q <= '0;
         end else if (ls_gnt) begin
            if (!if_req) begin
               streak_q <= '0;
            end else if (streak_q != STREAK_MAX) begin
               streak_q <= streak_q + STREAK_W'(1);
            end
         end

         case (state_q)
            IDLE: begin
               if (if_gnt) begin
                  state_q     <= BUSY_IF;
                  mem_req_q   <= 1'b1;
                  mem_we_q    <= 1'b0;
                  mem_addr_q  <= {if_addr[31:2], 2'b00};
                  mem_be_q    <= 4'b1111;
                  mem_wdata_q <= '0;
               end else if (ls_gnt) begin
                  if (ls_misaligned_c) begin
                     // Rejected without touching memory; complete next cycle.
                     ls_rvalid_q <= 1'b1;
                     ls_err_q    <= 1'b1;
                     ls_rdata_q  <= '0;
                  end else begin
                     state_q     <= BUSY_LS;
                     mem_req_q   <= 1'b1;
                     mem_we_q    <= ls_we;
                     mem_addr_q  <= {ls_addr[31:2], 2'b00};
                     mem_be_q    <= 4'(ls_bsel << ls_addr[1:0]);
                     mem_wdata_q <= 32'(ls_wdata << {ls_addr[1:0], 3'b000});
                     ld_off_q    <= ls_addr[1:0];
                     ld_bsel_q   <= ls_bsel;
                     ld_signed_q <= ls_signed;
                     ld_we_q     <= ls_we;
                  end
               end
            end
            BUSY_IF: begin
               if (mem_ready) begin
                  state_q     <= IDLE;
                  mem_req_q   <= 1'b0;
                  if_rvalid_q <= 1'b1;
                  if_rdata_q  <= mem_rdata;
               end
            end
            BUSY_LS: begin
               if (mem_ready) begin
                  state_q     <= IDLE;
                  mem_req_q   <= 1'b0;
                  ls_rvalid_q <= 1'b1;
                  ls_rdata_q  <= ld_we_q ? 32'd0 : ld_data_c;
               end
            end
            default: begin
               state_q   <= IDLE;
               mem_req_q <= 1'b0;
            end
         endcase
      end
   end

   assign if_rvalid = if_rvalid_q;
   assign if_rdata  = if_rdata_q;
   assign ls_rvalid = ls_rvalid_q;
   assign ls_rdata  = ls_rdata_q;
   assign ls_err    = ls_err_q;
   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_be    = mem_be_q;
   assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a table of single transactions with
// hand-computed expectations, plus sequences for arbitration and reset.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_gnt;
   logic        if_rvalid;
   logic [31:0] if_rdata;
   logic        ls_req;
   logic        ls_we;
   logic [31:0] ls_addr;
   logic [3:0]  ls_bsel;
   logic        ls_signed;
   logic [31:0] ls_wdata;
   logic        ls_gnt;
   logic        ls_rvalid;
   logic [31:0] ls_rdata;
   logic        ls_err;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_ready;
   logic [31:0] mem_rdata;

   int n_checks = 0;
   int n_fail   = 0;

   mem_arbiter #(.MAX_STREAK(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
      .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_bsel(ls_bsel),
      .ls_signed(ls_signed), .ls_wdata(ls_wdata), .ls_gnt(ls_gnt),
      .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata), .ls_err(ls_err),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
      .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        is_ls;
      logic        we;
      logic [31:0] addr;
      logic [3:0]  bsel;
      logic        sgn;
      logic [31:0] wdata;
      logic [31:0] mrdata;
      logic        exp_err;
      logic [31:0] exp_addr;
      logic [3:0]  exp_be;
      logic [31:0] exp_wdata;
      logic [31:0] exp_rdata;
   } vec_t;

   localparam int unsigned NVEC = 13;
   vec_t vecs [NVEC];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic idle_inputs();
      if_req    = 1'b0;
      if_addr   = '0;
      ls_req    = 1'b0;
      ls_we     = 1'b0;
      ls_addr   = '0;
      ls_bsel   = 4'b0000;
      ls_signed = 1'b0;
      ls_wdata  = '0;
      mem_ready = 1'b0;
      mem_rdata = '0;
   endtask

   // Request, take the grant, answer at the earliest cycle, check the result.
   task automatic run_vec(input int idx, input vec_t v);
      bit got;
      got = 1'b0;
      @(negedge clk);
      if (v.is_ls) begin
         ls_req = 1'b1; ls_we = v.we; ls_addr = v.addr; ls_bsel = v.bsel;
         ls_signed = v.sgn; ls_wdata = v.wdata;
      end else begin
         if_req = 1'b1; if_addr = v.addr;
      end
      #1;
      for (int c = 0; c < 10; c++) begin
         if (v.is_ls ? ls_gnt : if_gnt) begin
            got = 1'b1;
            break;
         end
         @(negedge clk); #1;
      end
      chk($sformatf("v%0d_grant", idx), 32'(got), 32'd1);
      if (!got) begin
         if_req = 1'b0; ls_req = 1'b0;
         return;
      end
      chk($sformatf("v%0d_excl", idx), 32'(if_gnt & ls_gnt), 32'd0);
      @(posedge clk); #1;
      if_req = 1'b0; ls_req = 1'b0;
      @(negedge clk);
      if (v.exp_err) begin
         chk($sformatf("v%0d_err_memreq", idx), 32'(mem_req), 32'd0);
         chk($sformatf("v%0d_err_rvalid", idx), 32'(ls_rvalid), 32'd1);
         chk($sformatf("v%0d_err_flag", idx), 32'(ls_err), 32'd1);
         chk($sformatf("v%0d_err_rdata", idx), ls_rdata, 32'd0);
         return;
      end
      chk($sformatf("v%0d_memreq", idx), 32'(mem_req), 32'd1);
      chk($sformatf("v%0d_memwe", idx), 32'(mem_we), 32'(v.is_ls & v.we));
      chk($sformatf("v%0d_memaddr", idx), mem_addr, v.exp_addr);
      chk($sformatf("v%0d_membe", idx), 32'(mem_be), 32'(v.exp_be));
      if (v.is_ls && v.we) chk($sformatf("v%0d_memwdata", idx), mem_wdata, v.exp_wdata);
      mem_ready = 1'b1; mem_rdata = v.mrdata;
      @(posedge clk); #1;
      mem_ready = 1'b0; mem_rdata = '0;
      @(negedge clk);
      if (v.is_ls) begin
         chk($sformatf("v%0d_ls_rvalid", idx), 32'(ls_rvalid), 32'd1);
         chk($sformatf("v%0d_ls_err", idx), 32'(ls_err), 32'd0);
         chk($sformatf("v%0d_ls_rdata", idx), ls_rdata, v.exp_rdata);
         chk($sformatf("v%0d_if_rvalid", idx), 32'(if_rvalid), 32'd0);
      end else begin
         chk($sformatf("v%0d_if_rvalid", idx), 32'(if_rvalid), 32'd1);
         chk($sformatf("v%0d_if_rdata", idx), if_rdata, v.exp_rdata);
         chk($sformatf("v%0d_ls_rvalid", idx), 32'(ls_rvalid), 32'd0);
      end
      chk($sformatf("v%0d_memreq_done", idx), 32'(mem_req), 32'd0);
   endtask

   initial begin
      //            is_ls we  addr          bsel     sgn  wdata         mrdata        err  exp_addr      be       exp_wdata     exp_rdata
      vecs[0]  = '{1'b0, 1'b0, 32'h0000_0100, 4'b0000, 1'b0, 32'h0,         32'h0000_0013, 1'b0, 32'h0000_0100, 4'b1111, 32'h0,         32'h0000_0013};
      vecs[1]  = '{1'b1, 1'b0, 32'h0000_0203, 4'b0001, 1'b1, 32'h0,         32'h80FF_FFFF, 1'b0, 32'h0000_0200, 4'b1000, 32'h0,         32'hFFFF_FF80};
      vecs[2]  = '{1'b1, 1'b0, 32'h0000_0203, 4'b0001, 1'b0, 32'h0,         32'h80FF_FFFF, 1'b0, 32'h0000_0200, 4'b1000, 32'h0,         32'h0000_0080};
      vecs[3]  = '{1'b1, 1'b1, 32'h0000_0202, 4'b0011, 1'b0, 32'h0000_BEEF, 32'h1234_5678, 1'b0, 32'h0000_0200, 4'b1100, 32'hBEEF_0000, 32'h0};
      vecs[4]  = '{1'b1, 1'b0, 32'h0000_0201, 4'b1111, 1'b0, 32'h0,         32'h0,         1'b1, 32'h0,         4'b0000, 32'h0,         32'h0};
      vecs[5]  = '{1'b1, 1'b0, 32'h0000_0202, 4'b0011, 1'b1, 32'h0,         32'h8001_1234, 1'b0, 32'h0000_0200, 4'b1100, 32'h0,         32'hFFFF_8001};
      vecs[6]  = '{1'b1, 1'b0, 32'h0000_0200, 4'b0011, 1'b0, 32'h0,         32'h1234_ABCD, 1'b0, 32'h0000_0200, 4'b0011, 32'h0,         32'h0000_ABCD};
      vecs[7]  = '{1'b1, 1'b1, 32'h0000_0101, 4'b0001, 1'b0, 32'h0000_00A5, 32'hFFFF_FFFF, 1'b0, 32'h0000_0100, 4'b0010, 32'h0000_A500, 32'h0};
      vecs[8]  = '{1'b1, 1'b0, 32'h0000_0300, 4'b1111, 1'b1, 32'h0,         32'hDEAD_BEEF, 1'b0, 32'h0000_0300, 4'b1111, 32'h0,         32'hDEAD_BEEF};
      vecs[9]  = '{1'b1, 1'b0, 32'h0000_0203, 4'b0011, 1'b0, 32'h0,         32'h0,         1'b1, 32'h0,         4'b0000, 32'h0,         32'h0};
      vecs[10] = '{1'b1, 1'b1, 32'h0000_0302, 4'b1111, 1'b0, 32'h1111_2222, 32'h0,         1'b1, 32'h0,         4'b0000, 32'h0,         32'h0};
      vecs[11] = '{1'b0, 1'b0, 32'h0000_0107, 4'b0000, 1'b0, 32'h0,         32'hCAFE_F00D, 1'b0, 32'h0000_0104, 4'b1111, 32'h0,         32'hCAFE_F00D};
      vecs[12] = '{1'b1, 1'b0, 32'h0000_0202, 4'b0001, 1'b1, 32'h0,         32'h1280_3456, 1'b0, 32'h0000_0200, 4'b0100, 32'h0,         32'hFFFF_FF80};

      // reset state, with both requests asserted
      idle_inputs();
      rst_n = 1'b0;
      if_req = 1'b1; ls_req = 1'b1; ls_bsel = 4'b1111;
      #12;
      chk("rst_if_gnt", 32'(if_gnt), 32'd0);
      chk("rst_ls_gnt", 32'(ls_gnt), 32'd0);
      chk("rst_mem_req", 32'(mem_req), 32'd0);
      chk("rst_rvalids", 32'({if_rvalid, ls_rvalid, ls_err}), 32'd0);
      chk("rst_cmd", mem_addr | mem_wdata | 32'(mem_be) | 32'(mem_we), 32'd0);
      chk("rst_rdata", if_rdata | ls_rdata, 32'd0);
      idle_inputs();
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < int'(NVEC); i++) run_vec(i, vecs[i]);

      // arbitration with both ports requesting continuously
      begin
         bit exp_ls [7];
         int n;
         bit drop_if;
         exp_ls = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
         n = 0;
         drop_if = 1'b0;
         @(negedge clk);
         if_req = 1'b1; if_addr = 32'h0000_0500;
         ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h0000_0400; ls_bsel = 4'b1111;
         #1;
         for (int cyc = 0; cyc < 60 && n < 7; cyc++) begin
            chk("arb_excl", 32'(if_gnt & ls_gnt), 32'd0);
            if (mem_req) chk("arb_busy_nognt", 32'(if_gnt | ls_gnt), 32'd0);
            mem_ready = mem_req; mem_rdata = 32'h0000_0001;
            if (if_gnt || ls_gnt) begin
               chk($sformatf("arb_grant%0d_is_ls", n), 32'(ls_gnt), 32'(exp_ls[n]));
               drop_if = if_gnt;
               n++;
            end
            @(posedge clk); #1;
            if (drop_if) if_req = 1'b0;
            drop_if = 1'b0;
            @(negedge clk); #1;
         end
         chk("arb_grant_count", 32'(n), 32'd7);
         ls_req = 1'b0; if_req = 1'b0;
         for (int c = 0; c < 4; c++) begin
            @(negedge clk); mem_ready = mem_req;
            @(posedge clk); #1; mem_ready = 1'b0;
         end
      end

      // reset while a load is stalled in memory
      @(negedge clk);
      ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h0000_0600; ls_bsel = 4'b1111;
      #1;
      chk("rst2_ls_gnt", 32'(ls_gnt), 32'd1);
      @(posedge clk); #1; ls_req = 1'b0;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         chk("stall_mem_req", 32'(mem_req), 32'd1);
         chk("stall_mem_addr", mem_addr, 32'h0000_0600);
         chk("stall_no_rvalid", 32'(ls_rvalid), 32'd0);
      end
      #2;
      rst_n = 1'b0;
      if_req = 1'b1; ls_req = 1'b1;
      #1;
      chk("rst2_mem_req", 32'(mem_req), 32'd0);
      chk("rst2_cmd", mem_addr | 32'(mem_be), 32'd0);
      chk("rst2_gnts", 32'({if_gnt, ls_gnt}), 32'd0);
      mem_ready = 1'b1;
      @(negedge clk);
      if_req = 1'b0; ls_req = 1'b0;
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("post_rst_no_rvalid", 32'(ls_rvalid | if_rvalid), 32'd0);
         chk("post_rst_no_memreq", 32'(mem_req), 32'd0);
      end
      mem_ready = 1'b0;
      run_vec(99, vecs[0]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Global time limit so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
